// File: rtl/sdram_arbiter_if.sv
// Bundle of requester-side and sdram-side signals around the two-port arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface sdram_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16,
    parameter int BW = 2
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [BW-1:0] be0;
    logic [BW-1:0] be1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic          err0;
    logic          err1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1,
        input  mem_rdata, mem_ack,
        output ack0, ack1, err0, err1, rdata0, rdata1,
        output mem_address, mem_be, mem_wdata, mem_rden, mem_wren, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1,
        output mem_rdata, mem_ack,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
        input  mem_address, mem_be, mem_wdata, mem_rden, mem_wren, busy
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter for two requesters (0 = fetch, 1 = load/store) in front of
// the sdram controller's single command port, with a completion timeout.
module sdram_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int BW      = 2,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    sdram_arbiter_if.slave  bus
);
    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_lastGnt;
    logic          r_gnt;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_memAddress;
    logic [BW-1:0] r_memBe;
    logic [DW-1:0] r_memWdata;
    logic          r_memRden;
    logic          r_memWren;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_err0;
    logic          r_err1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic w_anyReq;
    logic w_winner;
    logic w_done;

    // On contention the port that did not win last time goes next.
    assign w_anyReq = bus.req0 | bus.req1;
    assign w_winner = (bus.req0 & bus.req1) ? ~r_lastGnt : bus.req1;
    assign w_done   = bus.mem_ack | (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lastGnt    <= 1'b1;
            r_gnt        <= 1'b0;
            r_cnt        <= '0;
            r_memAddress <= '0;
            r_memBe      <= '0;
            r_memWdata   <= '0;
            r_memRden    <= 1'b0;
            r_memWren    <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_gnt        <= w_winner;
                        r_lastGnt    <= w_winner;
                        r_memAddress <= w_winner ? bus.addr1  : bus.addr0;
                        r_memBe      <= w_winner ? bus.be1    : bus.be0;
                        r_memWdata   <= w_winner ? bus.wdata1 : bus.wdata0;
                        r_memRden    <= w_winner ? ~bus.we1   : ~bus.we0;
                        r_memWren    <= w_winner ? bus.we1    : bus.we0;
                        r_cnt        <= '0;
                        r_state      <= BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A completion on the last allowed cycle still counts as success.
                    if (w_done) begin
                        r_memRden <= 1'b0;
                        r_memWren <= 1'b0;
                        r_ack0    <= ~r_gnt;
                        r_ack1    <= r_gnt;
                        r_err0    <= ~r_gnt & ~bus.mem_ack;
                        r_err1    <= r_gnt & ~bus.mem_ack;
                        r_state   <= RESP;
                        if (bus.mem_ack) begin
                            if (!r_memWren) begin
                                if (r_gnt) r_rdata1 <= bus.mem_rdata;
                                else       r_rdata0 <= bus.mem_rdata;
                            end
                        end else begin
                            if (r_gnt) r_rdata1 <= '0;
                            else       r_rdata0 <= '0;
                        end
                    end
                end
                RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_address = r_memAddress;
    assign bus.mem_be      = r_memBe;
    assign bus.mem_wdata   = r_memWdata;
    assign bus.mem_rden    = r_memRden;
    assign bus.mem_wren    = r_memWren;
    assign bus.ack0        = r_ack0;
    assign bus.ack1        = r_ack1;
    assign bus.err0        = r_err0;
    assign bus.err1        = r_err1;
    assign bus.rdata0      = r_rdata0;
    assign bus.rdata1      = r_rdata1;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model of the arbiter.
module tb_sdram_arbiter;
    localparam int AW      = 12;
    localparam int DW      = 16;
    localparam int BW      = 2;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;

    sdram_arbiter_if #(.AW(AW), .DW(DW), .BW(BW)) bus ();

    sdram_arbiter #(.AW(AW), .DW(DW), .BW(BW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int p, input logic r, input logic w,
                                 input logic [AW-1:0] a, input logic [BW-1:0] b,
                                 input logic [DW-1:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.be0 = b; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.be1 = b; bus.wdata1 = d;
        end
    endtask

    // Transaction-level model: one outstanding command, its age in cycles,
    // and a single response cycle once it completes or runs out of time.
    bit            mCmd;
    bit            mResp;
    bit            mPort;
    bit            mLast;
    bit            mWe;
    bit            mErr;
    int            mAge;
    logic [AW-1:0] mAddr;
    logic [BW-1:0] mBe;
    logic [DW-1:0] mWdata;
    logic [DW-1:0] mRdata [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mCmd = 0; mResp = 0; mPort = 0; mLast = 1; mWe = 0; mErr = 0; mAge = 0;
            mAddr = '0; mBe = '0; mWdata = '0;
            mRdata[0] = '0; mRdata[1] = '0;
        end else if (mResp) begin
            mResp = 0;
        end else if (mCmd) begin
            mAge++;
            if (bus.mem_ack || mAge == TIMEOUT) begin
                mErr = !bus.mem_ack;
                if (bus.mem_ack) begin
                    if (!mWe) mRdata[mPort] = bus.mem_rdata;
                end else begin
                    mRdata[mPort] = '0;
                end
                mCmd  = 0;
                mResp = 1;
            end
        end else if (bus.req0 || bus.req1) begin
            mPort  = (bus.req0 && bus.req1) ? !mLast : bus.req1;
            mLast  = mPort;
            mWe    = mPort ? bus.we1 : bus.we0;
            mAddr  = mPort ? bus.addr1 : bus.addr0;
            mBe    = mPort ? bus.be1 : bus.be0;
            mWdata = mPort ? bus.wdata1 : bus.wdata0;
            mAge   = 0;
            mCmd   = 1;
        end
    end

    // Every cycle, compare all outputs with the model away from the clock edge.
    always @(negedge clk) begin
        checkOutput("busy", 32'(bus.busy), 32'(mCmd | mResp));
        checkOutput("mem_rden", 32'(bus.mem_rden), 32'(mCmd & !mWe));
        checkOutput("mem_wren", 32'(bus.mem_wren), 32'(mCmd & mWe));
        if (mCmd) begin
            checkOutput("mem_address", 32'(bus.mem_address), 32'(mAddr));
            checkOutput("mem_be", 32'(bus.mem_be), 32'(mBe));
            checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(mWdata));
        end
        checkOutput("ack0", 32'(bus.ack0), 32'(mResp && !mPort));
        checkOutput("ack1", 32'(bus.ack1), 32'(mResp && mPort));
        if (mResp) checkOutput("err", 32'(mPort ? bus.err1 : bus.err0), 32'(mErr));
        checkOutput("rdata0", 32'(bus.rdata0), 32'(mRdata[0]));
        checkOutput("rdata1", 32'(bus.rdata1), 32'(mRdata[1]));
    end

    task automatic waitCmd(input string name);
        int n;
        n = 0;
        while (!(bus.mem_rden || bus.mem_wren) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " issued"}, 32'(bus.mem_rden | bus.mem_wren), 32'd1);
    endtask

    task automatic randomPort(input int p);
        logic r;
        logic a;
        r = (p == 0) ? bus.req0 : bus.req1;
        a = (p == 0) ? bus.ack0 : bus.ack1;
        if (!r) begin
            if ($urandom_range(0, 2) == 0)
                applyStimulus(p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), BW'($urandom), DW'($urandom));
        end else if (a) begin
            if ($urandom_range(0, 1) == 0)
                applyStimulus(p, 1'b0, 1'b0, '0, '0, '0);
            else
                applyStimulus(p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), BW'($urandom), DW'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi;
        int n;
        int acks;
        int order [4];

        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset rden", 32'(bus.mem_rden), 32'd0);
        checkOutput("reset rdata0", 32'(bus.rdata0), 32'd0);
        reset = 1'b0;

        // Single read, completion two cycles after rden rises.
        applyStimulus(0, 1'b1, 1'b0, 12'h0c0, 2'b11, 16'h0);
        waitCmd("t2 read");
        checkOutput("t2 addr", 32'(bus.mem_address), 32'h0c0);
        checkOutput("t2 rden", 32'(bus.mem_rden), 32'd1);
        repeat (2) @(negedge clk);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checkOutput("t2 ack0", 32'(bus.ack0), 32'd1);
        checkOutput("t2 rdata0", 32'(bus.rdata0), 32'hBEEF);
        checkOutput("t2 err0", 32'(bus.err0), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("t2 ack0 one cycle", 32'(bus.ack0), 32'd0);

        // Single write on port 1; read data bus noise must not reach rdata1.
        applyStimulus(1, 1'b1, 1'b1, 12'h010, 2'b01, 16'h1234);
        bus.mem_rdata = 16'hDEAD;
        waitCmd("t3 write");
        for (int k = 0; k < 3; k++) begin
            checkOutput("t3 wren", 32'(bus.mem_wren), 32'd1);
            checkOutput("t3 addr", 32'(bus.mem_address), 32'h010);
            checkOutput("t3 wdata", 32'(bus.mem_wdata), 32'h1234);
            checkOutput("t3 be", 32'(bus.mem_be), 32'h1);
            bus.mem_ack = (k == 2);
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        checkOutput("t3 ack1", 32'(bus.ack1), 32'd1);
        checkOutput("t3 rdata1", 32'(bus.rdata1), 32'd0);
        checkOutput("t3 rdata0 kept", 32'(bus.rdata0), 32'hBEEF);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);

        // Reset in the middle of a command drops it without a clock edge.
        applyStimulus(1, 1'b1, 1'b1, 12'h222, 2'b10, 16'h5555);
        waitCmd("t1 write");
        #2 reset = 1'b1;
        #1;
        checkOutput("t1 wren async", 32'(bus.mem_wren), 32'd0);
        checkOutput("t1 rden async", 32'(bus.mem_rden), 32'd0);
        checkOutput("t1 busy async", 32'(bus.busy), 32'd0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("t1 ack1", 32'(bus.ack1), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t1 ack1 after", 32'(bus.ack1), 32'd0);

        // Both ports requesting from reset alternate grants starting at 0.
        applyStimulus(0, 1'b1, 1'b0, 12'h100, 2'b11, '0);
        applyStimulus(1, 1'b1, 1'b0, 12'h200, 2'b11, '0);
        acks = 0;
        n = 0;
        while (acks < 4 && n < 80) begin
            checkOutput("t4 both acks", 32'(bus.ack0 & bus.ack1), 32'd0);
            if (bus.ack0 || bus.ack1) begin
                order[acks] = bus.ack1 ? 1 : 0;
                acks++;
                if (acks == 4) begin
                    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
                    applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
                end
            end
            bus.mem_ack = bus.mem_rden;
            bus.mem_rdata = DW'(16'h7000 + n);
            @(negedge clk);
            n++;
        end
        bus.mem_ack = 1'b0;
        checkOutput("t4 ack count", 32'(acks), 32'd4);
        for (int i = 0; i < acks; i++)
            checkOutput("t4 grant order", 32'(order[i]), 32'(i % 2));
        @(negedge clk);

        // No completion: abort after exactly TIMEOUT cycles of rden.
        bus.mem_rdata = 16'hA5A5;
        applyStimulus(0, 1'b1, 1'b0, 12'h3ff, 2'b11, '0);
        hi = 0;
        n = 0;
        while (!bus.ack0 && n < 200) begin
            if (bus.mem_rden) hi++;
            @(negedge clk);
            n++;
        end
        checkOutput("t5 ack0", 32'(bus.ack0), 32'd1);
        checkOutput("t5 rden cycles", 32'(hi), 32'd64);
        checkOutput("t5 err0", 32'(bus.err0), 32'd1);
        checkOutput("t5 rdata0", 32'(bus.rdata0), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);

        // Completion on the very last allowed cycle is a success.
        bus.mem_rdata = 16'h5A5A;
        applyStimulus(1, 1'b1, 1'b0, 12'h0ab, 2'b11, '0);
        hi = 0;
        n = 0;
        while (!bus.ack1 && n < 200) begin
            if (bus.mem_rden) begin
                hi++;
                bus.mem_ack = (hi == TIMEOUT);
            end else begin
                bus.mem_ack = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.mem_ack = 1'b0;
        checkOutput("t6 ack1", 32'(bus.ack1), 32'd1);
        checkOutput("t6 err1", 32'(bus.err1), 32'd0);
        checkOutput("t6 rdata1", 32'(bus.rdata1), 32'h5A5A);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);

        // Stray completion while idle is ignored.
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checkOutput("t6 stray busy", 32'(bus.busy), 32'd0);
        checkOutput("t6 stray ack0", 32'(bus.ack0), 32'd0);
        checkOutput("t6 stray ack1", 32'(bus.ack1), 32'd0);
        @(negedge clk);
        checkOutput("t6 stray ack1 later", 32'(bus.ack1), 32'd0);

        // Randomized traffic from both requesters with a random-latency memory.
        for (int c = 0; c < 1500; c++) begin
            if (bus.mem_rden || bus.mem_wren)
                bus.mem_ack = ($urandom_range(0, 2) == 0);
            else
                bus.mem_ack = ($urandom_range(0, 9) == 0);
            bus.mem_rdata = DW'($urandom);
            randomPort(0);
            randomPort(1);
            @(negedge clk);
        end
        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        bus.mem_ack = 1'b0;
        repeat (80) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
